boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream master for the on-chip instruction/data RAM controller: receives a firmware image as a byte stream from the UART receiver and writes it word by word into RAM over the picorv32-style native memory bus.
- Holds the CPU in reset until the image is loaded and its checksum verified.
- An external bus mux selects this block as RAM master while busy=1 and the CPU otherwise.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 32768, largest accepted image length in 32-bit words.
- TIMEOUT, 255, cycles to wait for mem_ready before aborting.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- mem_valid  out  1  write request to RAM
- mem_instr  out  1  constant 0
- mem_wstrb  out  4  byte enables, 4'hF during a write, else 4'h0
- mem_addr  out  32  byte address of current write
- mem_wdata  out  32  write data, little-endian assembled
- mem_ready  in  1  RAM acknowledge
- busy  out  1  high from magic byte until DONE or ERROR
- done  out  1  sticky: image loaded and verified
- err_code  out  3  0 none, 1 checksum, 2 bad length, 3 rx overrun, 4 mem timeout
- cpu_resetn  out  1  CPU reset, low until done=1

Behaviour:
- Reset, asynchronous: all outputs 0, mem_addr=BASE_ADDR, state IDLE, internal counters and sum cleared.
- Frame format: 0xA5, length L as 16 bits little-endian (words), 4*L data bytes little-endian per word, 1 checksum byte = 8-bit sum of all data bytes mod 256.
- States and transitions:
  - IDLE: bytes other than 0xA5 are ignored; 0xA5 -> LEN0, busy=1.
  - LEN0 -> LEN1 on the next byte. After LEN1: L > MAX_WORDS -> ERROR(2); L=0 -> CSUM; otherwise -> DATA.
  - DATA: bytes shift into a 4-byte assembly register, first byte -> wdata[7:0]. On the 4th byte the word moves into the write register and a write is issued.
  - After the last word -> DRAIN, which waits for the outstanding write, then -> CSUM.
  - CSUM: next byte compared with the running sum. Match -> DONE; mismatch -> ERROR(1).
  - DONE: done=1, busy=0, cpu_resetn=1; all further rx ignored until reset.
  - ERROR: busy=0, cpu_resetn stays 0. A new 0xA5 clears err_code, sum and counters and goes to LEN0.
- Write handshake:
  - The cycle after the word completes, drive mem_valid=1, wstrb=4'hF, addr and wdata.
  - Hold all of them stable until mem_ready is sampled 1.
  - Deassert mem_valid in the next cycle; wstrb returns to 0 and addr += 4.
  - At least one idle cycle separates consecutive writes, because RAM ready stays high while valid is held.
- Timeout: a cycle counter runs while mem_valid=1. Reaching TIMEOUT without mem_ready -> drop mem_valid, ERROR(4).
- Overrun: a 4th byte completes a new word while the previous write is still pending -> ERROR(3). Bytes 1-3 may arrive during a pending write.
- Byte in the same cycle as mem_ready: both are processed, no loss.
- Checksum uses 8-bit wrap-around addition. The length field and magic byte are excluded from the sum.
- Address increments modulo 2^32. No bounds check other than MAX_WORDS.

Test Plan:
- Nominal load: A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82. Expect writes of 32'h00000013 @0x0 and 32'h0000006F @0x4, then done=1, cpu_resetn=1, err_code=0.
- Checksum error: same frame with last byte 0x83. Expect both writes, err_code=1, cpu_resetn=0. Re-sending the correct frame then gives done=1.
- Bad length: A5 01 80 with MAX_WORDS=32768 (L=32769). Expect ERROR(2) and no mem_valid.
- Zero length and noise: 00 FF A5 00 00 00. Expect leading noise ignored, no writes, done=1.
- Slow RAM / timeout:
  - mem_ready delayed 10 cycles: mem_valid, addr and wdata stable for 10 cycles, load completes.
  - mem_ready never asserted with TIMEOUT=255: mem_valid drops after 255 cycles, err_code=4.
- Overrun and reset:
  - Bytes of word 2 arrive back-to-back while the write of word 1 stalls: err_code=3.
  - resetn pulsed low mid-DATA: all outputs at reset values immediately, and a fresh frame then loads correctly.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: receives a framed firmware image from the UART byte stream,
// writes it word by word to RAM over a native valid/ready memory bus, checks
// the trailing checksum and releases the CPU from reset once it matches.
//
// Write handshake: a request is launched by raising mem_valid together with
// mem_addr, mem_wdata and mem_wstrb=4'hF. All of them hold steady until
// mem_ready is sampled high on a rising edge. mem_valid drops in the
// following cycle, and mem_addr advances by 4 at the same time.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'd32768,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code,
    output logic        cpu_resetn,
    output logic [2:0]  state_dbg
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [7:0] MAGIC = 8'hA5;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_CSUM = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_OVR  = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    err_q, err_d;
    logic [23:0]   asm_q, asm_d;          // first three bytes of the word in progress
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]   words_left_q, words_left_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          valid_q, valid_d;
    logic          defer_q, defer_d;      // word waits one idle cycle behind a just-acked write
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    csum_byte_q, csum_byte_d;
    logic          csum_pend_q, csum_pend_d; // checksum byte arrived while draining

    logic          ack;
    logic          stall;
    logic          tmo_hit;
    logic [31:0]   word_in;
    logic [15:0]   len_in;
    logic [7:0]    csum_in;

    assign ack     = valid_q & mem_ready;
    assign stall   = valid_q & ~mem_ready;
    assign tmo_hit = stall & (tmo_q == TMO_LAST);
    assign word_in = {rx_data, asm_q};
    assign len_in  = {rx_data, len_lo_q};
    assign csum_in = rx_valid ? rx_data : csum_byte_q;

    // Next-state, frame parsing and write-request sequencing
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        asm_d        = asm_q;
        byte_cnt_d   = byte_cnt_q;
        words_left_d = words_left_q;
        sum_d        = sum_q;
        len_lo_d     = len_lo_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        defer_d      = defer_q;
        tmo_d        = stall ? tmo_q + TW'(1) : '0;
        csum_byte_d  = csum_byte_q;
        csum_pend_d  = csum_pend_q;

        // Bus side: retire an acknowledged write, launch a deferred one
        if (ack) begin
            valid_d = 1'b0;
            addr_d  = addr_q + 32'd4;
        end
        if (defer_q) begin
            valid_d = 1'b1;
            defer_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (rx_valid && rx_data == MAGIC) begin
                    state_d      = S_LEN0;
                    err_d        = ERR_NONE;
                    sum_d        = 8'd0;
                    byte_cnt_d   = 2'd0;
                    words_left_d = 16'd0;
                    addr_d       = BASE_ADDR;
                    valid_d      = 1'b0;
                    defer_d      = 1'b0;
                    csum_pend_d  = 1'b0;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    words_left_d = len_in;
                    if ({16'd0, len_in} > MAX_WORDS) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LEN;
                    end else if (len_in == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    sum_d      = sum_q + rx_data;
                    asm_d      = {rx_data, asm_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (stall || defer_q) begin
                            // previous word still on the bus: nowhere to put this one
                            state_d = S_ERROR;
                            err_d   = ERR_OVR;
                            valid_d = 1'b0;
                            defer_d = 1'b0;
                        end else begin
                            wdata_d      = word_in;
                            words_left_d = words_left_q - 16'd1;
                            // an ack this cycle forces one idle bus cycle first
                            if (ack) begin
                                defer_d = 1'b1;
                            end else begin
                                valid_d = 1'b1;
                            end
                            if (words_left_q == 16'd1) begin
                                state_d = S_DRAIN;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (rx_valid) begin
                    csum_byte_d = rx_data;
                    csum_pend_d = 1'b1;
                end
                if (ack) begin
                    csum_pend_d = 1'b0;
                    if (rx_valid || csum_pend_q) begin
                        if (csum_in == sum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_CSUM;
                        end
                    end else begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RAM never answered: abandon the request
        if (tmo_hit) begin
            state_d     = S_ERROR;
            err_d       = ERR_TMO;
            valid_d     = 1'b0;
            defer_d     = 1'b0;
            csum_pend_d = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and bus registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q        <= ERR_NONE;
            asm_q        <= 24'd0;
            byte_cnt_q   <= 2'd0;
            words_left_q <= 16'd0;
            sum_q        <= 8'd0;
            len_lo_q     <= 8'd0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= 32'd0;
            valid_q      <= 1'b0;
            defer_q      <= 1'b0;
            tmo_q        <= '0;
            csum_byte_q  <= 8'd0;
            csum_pend_q  <= 1'b0;
        end else begin
            err_q        <= err_d;
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            words_left_q <= words_left_d;
            sum_q        <= sum_d;
            len_lo_q     <= len_lo_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            valid_q      <= valid_d;
            defer_q      <= defer_d;
            tmo_q        <= tmo_d;
            csum_byte_q  <= csum_byte_d;
            csum_pend_q  <= csum_pend_d;
        end
    end

    assign mem_valid  = valid_q;
    assign mem_instr  = 1'b0;
    assign mem_wstrb  = valid_q ? 4'hF : 4'h0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                        (state_q == S_DRAIN) || (state_q == S_CSUM);
    assign done       = (state_q == S_DONE);
    assign cpu_resetn = (state_q == S_DONE);
    assign err_code   = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a RAM responder with programmable latency,
// a bus monitor feeding an observed-write queue, an expected-write queue and
// a linear sequence of frames with hand-computed results.
module tb_boot_loader;

    logic        clk;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;
    logic        cpu_resetn;
    logic [2:0]  state_dbg;

    boot_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(32'd32768),
        .TIMEOUT  (255)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .cpu_resetn(cpu_resetn),
        .state_dbg (state_dbg)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int byte_gap    = 1;
    int ram_delay   = 0;
    bit ram_never   = 1'b0;
    int wcnt        = 0;
    int vlen        = 0;
    int last_len    = 0;
    int valid_cycles = 0;
    int stable_err  = 0;
    int vc_snap     = 0;
    logic [31:0] a0, d0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  fq[$];

    // RAM responder and bus monitor (sampled on the falling edge)
    always @(negedge clk) begin
        if (mem_valid) begin
            if (vlen == 0) begin
                a0 = mem_addr;
                d0 = mem_wdata;
            end else if (mem_addr !== a0 || mem_wdata !== d0) begin
                stable_err++;
            end
            if (mem_wstrb !== 4'hF) stable_err++;
            vlen++;
            valid_cycles++;
        end else begin
            if (mem_wstrb !== 4'h0) stable_err++;
            if (vlen != 0) last_len = vlen;
            vlen = 0;
        end
        if (mem_valid && !mem_ready) begin
            wcnt++;
            if (!ram_never && wcnt > ram_delay) begin
                mem_ready = 1'b1;
                obs_q.push_back({mem_addr, mem_wdata});
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (byte_gap - 1) @(negedge clk);
    endtask

    task automatic send_q();
        foreach (fq[i]) send_byte(fq[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_end(input int budget);
        int i;
        i = 0;
        while (i < budget && !done && err_code == 3'd0) begin
            @(negedge clk);
            i++;
        end
        check("end_within_budget", 64'(i < budget), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_writes();
        check("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check("write_addr_data", obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_nominal();
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0000_006F});
    endtask

    initial begin
        resetn    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_instr", mem_instr, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_cpu_resetn", cpu_resetn, 0);
        resetn = 1'b1;
        @(negedge clk);

        // nominal load: sum 0x13+0x6F = 0x82
        send_byte(8'hA5);
        check("nom_busy_after_magic", busy, 1);
        fq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_q();
        expect_nominal();
        wait_end(200);
        check("nom_done", done, 1);
        check("nom_cpu_resetn", cpu_resetn, 1);
        check("nom_err", err_code, 0);
        check("nom_busy", busy, 0);
        check_writes();
        check("nom_stable", 64'(stable_err), 64'd0);

        // DONE ignores further traffic
        send_byte(8'hA5);
        send_byte(8'h13);
        check("done_ignore_busy", busy, 0);
        check("done_ignore_done", done, 1);

        // checksum error, then recovery by resending
        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        send_q();
        expect_nominal();
        wait_end(200);
        check("csum_err", err_code, 1);
        check("csum_cpu_resetn", cpu_resetn, 0);
        check("csum_done", done, 0);
        check("csum_busy", busy, 0);
        check_writes();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_q();
        expect_nominal();
        wait_end(200);
        check("resend_done", done, 1);
        check("resend_err", err_code, 0);
        check_writes();

        // bad length: L = 0x8001 > 32768
        do_reset();
        vc_snap = valid_cycles;
        fq = '{8'hA5, 8'h01, 8'h80};
        send_q();
        wait_end(50);
        check("badlen_err", err_code, 2);
        check("badlen_busy", busy, 0);
        check("badlen_no_valid", 64'(valid_cycles), 64'(vc_snap));

        // leading noise then zero-length frame
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_busy", busy, 0);
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        wait_end(50);
        check("zero_done", done, 1);
        check("zero_err", err_code, 0);
        check_writes();

        // slow RAM: ready after 10 cycles of mem_valid, checksum lands mid-drain
        do_reset();
        ram_delay  = 9;
        byte_gap   = 4;
        stable_err = 0;
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_q();
        expect_nominal();
        wait_end(600);
        check("slow_done", done, 1);
        check("slow_err", err_code, 0);
        check("slow_valid_len", 64'(last_len), 64'd10);
        check("slow_stable", 64'(stable_err), 64'd0);
        check_writes();
        ram_delay = 0;
        byte_gap  = 1;

        // RAM never answers: mem_valid held 255 cycles then dropped
        do_reset();
        ram_never = 1'b1;
        fq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_q();
        wait_end(600);
        check("tmo_err", err_code, 4);
        check("tmo_valid_len", 64'(last_len), 64'd255);
        check("tmo_mem_valid", mem_valid, 0);
        check("tmo_cpu_resetn", cpu_resetn, 0);
        check("tmo_busy", busy, 0);
        check_writes();
        ram_never = 1'b0;

        // overrun: word 2 completes while word 1 is still stalled
        do_reset();
        ram_delay = 50;
        fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_q();
        wait_end(100);
        check("ovr_err", err_code, 3);
        check("ovr_mem_valid", mem_valid, 0);
        check("ovr_busy", busy, 0);
        check_writes();
        ram_delay = 0;

        // asynchronous reset mid-DATA, then a fresh load
        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F};
        send_q();
        check("mid_busy", busy, 1);
        check("mid_addr_advanced", mem_addr, 32'h4);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_valid", mem_valid, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_wstrb", mem_wstrb, 0);
        check("arst_err", err_code, 0);
        check("arst_done", done, 0);
        check("arst_cpu_resetn", cpu_resetn, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_q();
        expect_nominal();
        wait_end(200);
        check("post_rst_done", done, 1);
        check("post_rst_cpu_resetn", cpu_resetn, 1);
        check_writes();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
